decode: RTL and testbench

- Instruction decode stage of the LC3 core, directly downstream of the fetch stage.
- After fetch presents a PC address to instruction memory, this block waits out the memory read latency and latches the returned word into an instruction register (IR).
- It splits the IR into the opcode, register, immediate/offset and nzp fields that execute and fetch consume (opCode_in, offset_in, br_nzp on fetch).
- It then pulses execute_start to hand off to the execute stage.

---
 rtl/decode_if.sv | 41 ++++
 rtl/decode.sv | 95 +++++++++
 tb/tb_decode.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/decode_if.sv
// Bundles the LC3 decode stage's handshake, memory data and decoded field outputs.
// The master side drives decode_start and mem_dout; the slave side is the decode stage.
interface decode_if;
    logic        decode_start;
    logic [15:0] mem_dout;
    logic        busy;
    logic        execute_start;
    logic [15:0] ir_out;
    logic [3:0]  opCode_out;
    logic [2:0]  dr_out;
    logic [2:0]  sr1_out;
    logic [2:0]  sr2_out;
    logic        imm_mode;
    logic [15:0] imm5_sext;
    logic [15:0] offset6_sext;
    logic [8:0]  offset9_out;
    logic [15:0] offset9_sext;
    logic [15:0] offset11_sext;
    logic [15:0] trapvect_out;
    logic [2:0]  br_nzp;
    logic        reg_write_en;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;

    modport slave (
        input  decode_start, mem_dout,
        output busy, execute_start, ir_out, opCode_out, dr_out, sr1_out, sr2_out,
               imm_mode, imm5_sext, offset6_sext, offset9_out, offset9_sext,
               offset11_sext, trapvect_out, br_nzp, reg_write_en, mem_read,
               mem_write, illegal
    );

    modport master (
        output decode_start, mem_dout,
        input  busy, execute_start, ir_out, opCode_out, dr_out, sr1_out, sr2_out,
               imm_mode, imm5_sext, offset6_sext, offset9_out, offset9_sext,
               offset11_sext, trapvect_out, br_nzp, reg_write_en, mem_read,
               mem_write, illegal
    );
endinterface

// File: rtl/decode.sv
// LC3 decode stage: waits out instruction memory latency, latches the IR,
// splits it into fields/control flags and pulses execute_start.
module decode #(
    parameter int MEM_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    decode_if.slave  dif
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] ir_q, ir_d;
    logic [3:0]  op;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (dif.decode_start) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    ir_d    = dif.mem_dout;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
        end
    end

    assign dif.busy          = (state_q != S_IDLE);
    assign dif.execute_start = (state_q == S_DONE);

    // Every field below depends only on the latched IR, never on mem_dout.
    assign op                = ir_q[15:12];
    assign dif.ir_out        = ir_q;
    assign dif.opCode_out    = op;
    assign dif.dr_out        = (op == 4'b0100 || op == 4'b1111) ? 3'd7 : ir_q[11:9];
    assign dif.sr1_out       = ir_q[8:6];
    assign dif.sr2_out       = ir_q[2:0];
    assign dif.imm_mode      = ir_q[5];
    assign dif.imm5_sext     = {{11{ir_q[4]}}, ir_q[4:0]};
    assign dif.offset6_sext  = {{10{ir_q[5]}}, ir_q[5:0]};
    assign dif.offset9_out   = ir_q[8:0];
    assign dif.offset9_sext  = {{7{ir_q[8]}}, ir_q[8:0]};
    assign dif.offset11_sext = {{5{ir_q[10]}}, ir_q[10:0]};
    assign dif.trapvect_out  = {8'h00, ir_q[7:0]};
    assign dif.br_nzp        = (op == 4'b0000) ? ir_q[11:9] : 3'b000;

    always_comb begin
        dif.reg_write_en = 1'b0;
        dif.mem_read     = 1'b0;
        dif.mem_write    = 1'b0;
        dif.illegal      = 1'b0;
        case (op)
            4'b0001, 4'b0101, 4'b1001, 4'b1110, 4'b0100, 4'b1111:
                dif.reg_write_en = 1'b1;
            4'b0010, 4'b1010, 4'b0110: begin
                dif.reg_write_en = 1'b1;
                dif.mem_read     = 1'b1;
            end
            4'b0011, 4'b1011, 4'b0111: dif.mem_write = 1'b1;
            4'b1000, 4'b1101:          dif.illegal   = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: one instance at MEM_LATENCY=1 (a) and one at 3 (b).
`timescale 1ns/1ps
module tb_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    decode_if a_if ();
    decode_if b_if ();

    decode #(.MEM_LATENCY(1)) u_a (.clk(clk), .rst_n(rst_n), .dif(a_if.slave));
    decode #(.MEM_LATENCY(3)) u_b (.clk(clk), .rst_n(rst_n), .dif(b_if.slave));

    // Pulse decode_start on instance a and return at the negedge inside the DONE cycle.
    task automatic issue_a(input logic [15:0] instr);
        @(negedge clk);
        a_if.decode_start = 1'b1;
        a_if.mem_dout     = instr;
        @(negedge clk);
        a_if.decode_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_if.decode_start = 1'b0; a_if.mem_dout = 16'hFFFF;
        b_if.decode_start = 1'b0; b_if.mem_dout = 16'hFFFF;
        repeat (5) @(negedge clk);
        n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", a_if.busy); end
        n_cmp++; if (a_if.execute_start !== 1'b0) begin n_bad++; $display("FAIL reset_exec got %b want 0", a_if.execute_start); end
        n_cmp++; if (a_if.ir_out !== 16'h0000) begin n_bad++; $display("FAIL reset_ir got %h want 0000", a_if.ir_out); end
        n_cmp++; if (a_if.opCode_out !== 4'd0) begin n_bad++; $display("FAIL reset_op got %h want 0", a_if.opCode_out); end
        n_cmp++; if (a_if.br_nzp !== 3'b000) begin n_bad++; $display("FAIL reset_nzp got %b want 000", a_if.br_nzp); end
        n_cmp++; if (a_if.dr_out !== 3'd0) begin n_bad++; $display("FAIL reset_dr got %0d want 0", a_if.dr_out); end
        n_cmp++; if ({a_if.reg_write_en, a_if.mem_read, a_if.mem_write, a_if.illegal} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags got %b want 0000", {a_if.reg_write_en, a_if.mem_read, a_if.mem_write, a_if.illegal}); end
        n_cmp++; if ({a_if.imm5_sext, a_if.offset9_sext, a_if.trapvect_out} !== 48'h0) begin
            n_bad++; $display("FAIL reset_fields got %h want 0", {a_if.imm5_sext, a_if.offset9_sext, a_if.trapvect_out}); end
        n_cmp++; if (b_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b got %b want 0", b_if.busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        @(negedge clk);
        a_if.decode_start = 1'b1; a_if.mem_dout = 16'h1261;
        @(negedge clk);
        a_if.decode_start = 1'b0;
        n_cmp++; if (a_if.busy !== 1'b1 || a_if.execute_start !== 1'b0) begin
            n_bad++; $display("FAIL add_wait busy/exec got %b%b want 10", a_if.busy, a_if.execute_start); end
        @(negedge clk);
        n_cmp++; if (a_if.execute_start !== 1'b1) begin n_bad++; $display("FAIL add_exec got %b want 1", a_if.execute_start); end
        n_cmp++; if (a_if.opCode_out !== 4'd1) begin n_bad++; $display("FAIL add_op got %h want 1", a_if.opCode_out); end
        n_cmp++; if (a_if.dr_out !== 3'd1 || a_if.sr1_out !== 3'd1) begin
            n_bad++; $display("FAIL add_regs got dr=%0d sr1=%0d want 1 1", a_if.dr_out, a_if.sr1_out); end
        n_cmp++; if (a_if.imm_mode !== 1'b1 || a_if.imm5_sext !== 16'h0001) begin
            n_bad++; $display("FAIL add_imm got %b %h want 1 0001", a_if.imm_mode, a_if.imm5_sext); end
        n_cmp++; if (a_if.reg_write_en !== 1'b1) begin n_bad++; $display("FAIL add_regwr got %b want 1", a_if.reg_write_en); end
        a_if.mem_dout = 16'hBEEF;
        @(negedge clk);
        n_cmp++; if (a_if.execute_start !== 1'b0 || a_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL add_end exec/busy got %b%b want 00", a_if.execute_start, a_if.busy); end
        @(negedge clk);
        n_cmp++; if (a_if.ir_out !== 16'h1261) begin n_bad++; $display("FAIL add_hold_ir got %h want 1261", a_if.ir_out); end
    endtask

    task automatic test_not_br;
        issue_a(16'h94FF);
        n_cmp++; if (a_if.opCode_out !== 4'd9 || a_if.dr_out !== 3'd2 || a_if.sr1_out !== 3'd3) begin
            n_bad++; $display("FAIL not_fields got op=%h dr=%0d sr1=%0d want 9 2 3", a_if.opCode_out, a_if.dr_out, a_if.sr1_out); end
        n_cmp++; if (a_if.reg_write_en !== 1'b1) begin n_bad++; $display("FAIL not_regwr got %b want 1", a_if.reg_write_en); end
        issue_a(16'h0DFD);
        n_cmp++; if (a_if.br_nzp !== 3'b110) begin n_bad++; $display("FAIL br_nzp got %b want 110", a_if.br_nzp); end
        n_cmp++; if (a_if.offset9_out !== 9'h1FD || a_if.offset9_sext !== 16'hFFFD) begin
            n_bad++; $display("FAIL br_off9 got %h %h want 1fd fffd", a_if.offset9_out, a_if.offset9_sext); end
        n_cmp++; if (a_if.reg_write_en !== 1'b0) begin n_bad++; $display("FAIL br_regwr got %b want 0", a_if.reg_write_en); end
    endtask

    task automatic test_mem_trap;
        issue_a(16'h697F);
        n_cmp++; if (a_if.mem_read !== 1'b1 || a_if.mem_write !== 1'b0) begin
            n_bad++; $display("FAIL ldr_flags got rd=%b wr=%b want 1 0", a_if.mem_read, a_if.mem_write); end
        n_cmp++; if (a_if.dr_out !== 3'd4 || a_if.sr1_out !== 3'd5 || a_if.offset6_sext !== 16'hFFFF) begin
            n_bad++; $display("FAIL ldr_fields got dr=%0d sr1=%0d off6=%h want 4 5 ffff", a_if.dr_out, a_if.sr1_out, a_if.offset6_sext); end
        issue_a(16'h7940);
        n_cmp++; if (a_if.mem_write !== 1'b1 || a_if.mem_read !== 1'b0 || a_if.reg_write_en !== 1'b0) begin
            n_bad++; $display("FAIL str_flags got wr=%b rd=%b rw=%b want 1 0 0", a_if.mem_write, a_if.mem_read, a_if.reg_write_en); end
        issue_a(16'hF025);
        n_cmp++; if (a_if.dr_out !== 3'd7 || a_if.trapvect_out !== 16'h0025 || a_if.reg_write_en !== 1'b1) begin
            n_bad++; $display("FAIL trap_fields got dr=%0d tv=%h rw=%b want 7 0025 1", a_if.dr_out, a_if.trapvect_out, a_if.reg_write_en); end
        issue_a(16'h4FFF);
        n_cmp++; if (a_if.dr_out !== 3'd7 || a_if.offset11_sext !== 16'hFFFF) begin
            n_bad++; $display("FAIL jsr_fields got dr=%0d off11=%h want 7 ffff", a_if.dr_out, a_if.offset11_sext); end
    endtask

    task automatic test_illegal;
        issue_a(16'hD000);
        n_cmp++; if (a_if.illegal !== 1'b1 || a_if.execute_start !== 1'b1) begin
            n_bad++; $display("FAIL illegal got ill=%b exec=%b want 1 1", a_if.illegal, a_if.execute_start); end
    endtask

    task automatic test_latency3;
        int pulses;
        @(negedge clk);
        b_if.decode_start = 1'b1; b_if.mem_dout = 16'h1261;   // held high across E0 and E1
        @(negedge clk);
        n_cmp++; if (b_if.busy !== 1'b1) begin n_bad++; $display("FAIL lat3_busy_e0 got %b want 1", b_if.busy); end
        @(negedge clk);
        b_if.decode_start = 1'b0;
        n_cmp++; if (b_if.busy !== 1'b1 || b_if.execute_start !== 1'b0) begin
            n_bad++; $display("FAIL lat3_e1 busy/exec got %b%b want 10", b_if.busy, b_if.execute_start); end
        @(negedge clk);
        b_if.mem_dout = 16'h5020;
        n_cmp++; if (b_if.execute_start !== 1'b0) begin n_bad++; $display("FAIL lat3_e2_exec got %b want 0", b_if.execute_start); end
        @(negedge clk);
        b_if.mem_dout = 16'h1261;
        n_cmp++; if (b_if.execute_start !== 1'b1) begin n_bad++; $display("FAIL lat3_e3_exec got %b want 1", b_if.execute_start); end
        n_cmp++; if (b_if.ir_out !== 16'h5020 || b_if.opCode_out !== 4'd5) begin
            n_bad++; $display("FAIL lat3_capture got %h op=%h want 5020 5", b_if.ir_out, b_if.opCode_out); end
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (b_if.execute_start === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0 || b_if.busy !== 1'b0) begin
            n_bad++; $display("FAIL lat3_no_second got pulses=%0d busy=%b want 0 0", pulses, b_if.busy); end
        n_cmp++; if (b_if.ir_out !== 16'h5020) begin n_bad++; $display("FAIL lat3_hold got %h want 5020", b_if.ir_out); end
    endtask

    task automatic test_abort;
        int pulses;
        @(negedge clk);
        b_if.decode_start = 1'b1; b_if.mem_dout = 16'hF025;
        @(negedge clk);
        b_if.decode_start = 1'b0;
        n_cmp++; if (b_if.busy !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy got %b want 1", b_if.busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b_if.busy !== 1'b0 || b_if.ir_out !== 16'h0000) begin
            n_bad++; $display("FAIL abort_async got busy=%b ir=%h want 0 0000", b_if.busy, b_if.ir_out); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (b_if.execute_start === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 0 || b_if.busy !== 1'b0 || b_if.ir_out !== 16'h0000) begin
            n_bad++; $display("FAIL abort_after got pulses=%0d busy=%b ir=%h want 0 0 0000", pulses, b_if.busy, b_if.ir_out); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_not_br();
        test_mem_trap();
        test_illegal();
        test_latency3();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
